// File: rtl/core_mem_router_pkg.sv
// Shared types and constants for the core data-port router.
// Holds the FSM state encoding, the default region map and width helpers.
package core_mem_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    FAULT
  } router_state_t;

  localparam int MAX_PORTS = 8;

  // Default two-port map: port1 = main memory, port0 = MMIO window.
  localparam logic [63:0] MEM_BASE  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MEM_MASK  = 64'hFFFF_FFFF_F000_0000;
  localparam logic [63:0] MMIO_BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MMIO_MASK = 64'hFFFF_FFFF_8000_0000;

  // Select index width; a single port still carries a 1-bit index.
  function automatic int sel_width(input int num_ports);
    return $clog2(num_ports > 1 ? num_ports : 2);
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/core_mem_router_if.sv
// Downstream request/response bundle between the router and its per-port FSMs.
// The router drives requests (master); the port FSMs answer (slave).
interface core_mem_router_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic                            req_we;
  logic [DATA_WIDTH-1:0]           req_wdata;
  logic [DATA_WIDTH/8-1:0]         req_wmask;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/core_mem_router_addr_decode.sv
// Combinational region decoder: address -> one-hot hit, port index, miss.
// Regions may overlap; the lowest matching port index wins.
module router_addr_decode
  import core_mem_router_pkg::*;
#(
  parameter int                              NUM_PORTS   = 2,
  parameter int                              ADDR_WIDTH  = 64,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = '0,
  localparam int                             SEL_W       = sel_width(NUM_PORTS)
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_PORTS-1:0]  o_hit,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_miss
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    o_hit  = '0;
    o_sel  = '0;
    o_miss = 1'b1;
    // Walk from the top down so the last (lowest-index) match overwrites the rest.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_sel    = SEL_W'(i);
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_mem_router.sv
// Routes the core data port to one of NUM_PORTS downstream ports through a
// registered request FSM with decode-error and response-timeout faults.
module core_mem_router
  import core_mem_router_pkg::*;
#(
  parameter int                              NUM_PORTS   = 2,
  parameter int                              ADDR_WIDTH  = 64,
  parameter int                              DATA_WIDTH  = 64,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = {MEM_BASE, MMIO_BASE},
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = {MEM_MASK, MMIO_MASK},
  parameter int                              TIMEOUT     = 1023
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   address_cpu,
  input  logic                    wen_cpu,
  input  logic                    ren_cpu,
  input  logic [DATA_WIDTH-1:0]   wdata_cpu,
  input  logic [DATA_WIDTH/8-1:0] wmask_cpu,
  output logic [DATA_WIDTH-1:0]   rdata_cpu,
  output logic                    mem_stall,
  output logic                    access_fault,
  core_mem_router_if.master       dn
);

  localparam int SEL_W  = sel_width(NUM_PORTS);
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam int MASK_W = DATA_WIDTH / 8;

  router_state_t           r_state;
  logic [SEL_W-1:0]        r_sel;
  logic [NUM_PORTS-1:0]    r_req_valid;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [MASK_W-1:0]       r_wmask;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_fault;

  logic [NUM_PORTS-1:0]    w_hit;
  logic [SEL_W-1:0]        w_sel;
  logic                    w_miss;
  logic                    w_access;
  logic                    w_accepted;
  logic                    w_resp;
  logic [DATA_WIDTH-1:0]   w_resp_data;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_timeout;

  router_addr_decode #(
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_decode (
    .i_addr(address_cpu),
    .o_hit (w_hit),
    .o_sel (w_sel),
    .o_miss(w_miss)
  );

  assign w_access   = wen_cpu | ren_cpu;
  assign w_accepted = |(r_req_valid & dn.req_ready);

  // Only the selected port's response is visible; the others are ignored.
  always_comb begin
    w_resp      = 1'b0;
    w_resp_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(r_sel) == i) begin
        w_resp      = dn.resp_valid[i];
        w_resp_data = dn.resp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == CNT_W'(TIMEOUT));

  assign mem_stall = ((r_state == IDLE) && w_access) ||
                     (r_state == REQ) || (r_state == WAIT);

  assign rdata_cpu    = r_rdata;
  assign access_fault = r_fault;
  assign dn.req_valid = r_req_valid;
  assign dn.req_addr  = r_addr;
  assign dn.req_we    = r_we;
  assign dn.req_wdata = r_wdata;
  assign dn.req_wmask = r_wmask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_req_valid <= '0;
      // NOTE: the payload is reset too because it drives visible outputs that must read 0 out of reset.
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
    end else begin
      // NOTE: nonblocking assignments throughout, so every branch reads the pre-edge state.
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_miss) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state     <= REQ;
              r_sel       <= w_sel;
              r_req_valid <= w_hit;
              r_addr      <= address_cpu;
              r_we        <= wen_cpu;
              r_wdata     <= wdata_cpu;
              r_wmask     <= wmask_cpu;
            end
          end
        end
        REQ: begin
          if (w_accepted) begin
            r_req_valid <= '0;
            r_cnt       <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (w_resp) begin
            if (!r_we) r_rdata <= w_resp_data;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        // The core advances during DONE/FAULT, so the request is not re-decoded here.
        DONE:    r_state <= IDLE;
        FAULT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_router.sv
// Scoreboard bench for core_mem_router: randomized core accesses against a
// region-map reference model, plus a 3-port overlapping-map instance.
module tb_core_mem_router;

  localparam int NP = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  localparam logic [AW-1:0] M_BASE [NP] = '{64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000};
  localparam logic [AW-1:0] M_MASK [NP] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F000_0000};

  typedef struct packed {
    logic [NP-1:0] oh;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } req_exp_t;

  typedef struct packed {
    logic          fault;
    logic [DW-1:0] rdata;
  } core_exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] address_cpu;
  logic          wen_cpu, ren_cpu;
  logic [DW-1:0] wdata_cpu;
  logic [MW-1:0] wmask_cpu;
  logic [DW-1:0] rdata_cpu;
  logic          mem_stall, access_fault;

  logic [AW-1:0] address2;
  logic          wen2, ren2;
  logic [DW-1:0] wdata2;
  logic [MW-1:0] wmask2;
  logic [DW-1:0] rdata2;
  logic          stall2, fault2;

  core_mem_router_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();
  core_mem_router_if #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn2 ();

  core_mem_router #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .address_cpu(address_cpu), .wen_cpu(wen_cpu),
    .ren_cpu(ren_cpu), .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu),
    .rdata_cpu(rdata_cpu), .mem_stall(mem_stall), .access_fault(access_fault),
    .dn(dn)
  );

  core_mem_router #(
    .NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .REGION_BASE({3*AW{1'b0}}), .REGION_MASK({3*AW{1'b0}}), .TIMEOUT(TO)
  ) dut2 (
    .clk(clk), .rstn(rstn), .address_cpu(address2), .wen_cpu(wen2),
    .ren_cpu(ren2), .wdata_cpu(wdata2), .wmask_cpu(wmask2),
    .rdata_cpu(rdata2), .mem_stall(stall2), .access_fault(fault2),
    .dn(dn2)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  req_exp_t  req_q[$];
  core_exp_t core_q[$];
  logic [DW-1:0] m_rdata;

  int            cfg_ready_delay;
  int            cfg_resp_delay;
  bit            cfg_no_resp;
  bit            cfg_noise;
  logic [DW-1:0] cfg_resp_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected DUT activity, expected none", name);
  endtask

  // Reference decode: first region (lowest index) whose masked address equals its base.
  function automatic int route(input logic [AW-1:0] a);
    for (int i = 0; i < NP; i++)
      if ((a & M_MASK[i]) == M_BASE[i]) return i;
    return -1;
  endfunction

  // Downstream port model: delayed ready, optional wrong-port noise, delayed response.
  initial begin : responder
    logic [NP-1:0] port_oh;
    int            p;
    dn.req_ready  = '0;
    dn.resp_valid = '0;
    dn.resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rstn && dn.req_valid != '0) begin
        port_oh = dn.req_valid;
        p       = port_oh[1] ? 1 : 0;
        repeat (cfg_ready_delay) @(negedge clk);
        #1 dn.req_ready = port_oh;
        @(negedge clk);
        #1 dn.req_ready = '0;
        if (!cfg_no_resp) begin
          for (int k = 1; k < cfg_resp_delay; k++) begin
            if (cfg_noise && k == 1) begin
              dn.resp_valid = ~port_oh;
              dn.resp_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            #1 dn.resp_valid = '0;
          end
          dn.resp_rdata = {$urandom, $urandom, $urandom, $urandom};
          dn.resp_rdata[p*DW +: DW] = cfg_resp_data;
          dn.resp_valid = port_oh;
          @(negedge clk);
          #1 dn.resp_valid = '0;
        end
      end
    end
  end

  // Request monitor: payload must match the expected request on every valid cycle.
  initial begin : req_mon
    bit       prev_v;
    req_exp_t a;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && dn.req_valid != '0) begin
        if (req_q.size() == 0) flag("req_unexpected");
        else begin
          a.oh    = dn.req_valid;
          a.addr  = dn.req_addr;
          a.we    = dn.req_we;
          a.wdata = dn.req_wdata;
          a.wmask = dn.req_wmask;
          check("req_payload", a, req_q[0]);
        end
        prev_v = 1'b1;
      end else begin
        if (prev_v && req_q.size() != 0) void'(req_q.pop_front());
        prev_v = 1'b0;
      end
    end
  end

  // Core-side monitor: a fault pulse or a stall release completes one access.
  initial begin : core_mon
    bit        prev_stall;
    core_exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) prev_stall = 1'b0;
      else begin
        if (access_fault || (prev_stall && !mem_stall)) begin
          if (core_q.size() == 0) flag("core_unexpected");
          else begin
            e = core_q.pop_front();
            check("core_fault", access_fault, e.fault);
            check("core_rdata", rdata_cpu, e.rdata);
          end
        end
        prev_stall = mem_stall;
      end
    end
  end

  task automatic access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, input int rdly, input int rsp,
                        input bit nresp, input bit noise, input logic [DW-1:0] rd);
    int        port, exp_lat, lat;
    req_exp_t  r;
    core_exp_t c;
    port            = route(addr);
    cfg_ready_delay = rdly;
    cfg_resp_delay  = rsp;
    cfg_no_resp     = nresp;
    cfg_noise       = noise;
    cfg_resp_data   = rd;
    if (port < 0) begin
      c.fault = 1'b1;
      c.rdata = '0;
      m_rdata = '0;
      exp_lat = 1;
    end else begin
      r.oh    = NP'(1) << port;
      r.addr  = addr;
      r.we    = we;
      r.wdata = wd;
      r.wmask = wm;
      req_q.push_back(r);
      if (nresp) begin
        c.fault = 1'b1;
        m_rdata = '0;
        exp_lat = 2 + rdly + TO;
      end else begin
        c.fault = 1'b0;
        if (!we) m_rdata = rd;
        exp_lat = 2 + rdly + rsp;
      end
      c.rdata = m_rdata;
    end
    core_q.push_back(c);
    @(negedge clk);
    #1;
    address_cpu = addr;
    wdata_cpu   = wd;
    wmask_cpu   = wm;
    wen_cpu     = we;
    ren_cpu     = we ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mem_stall && lat < 200);
    check("stall_release_cycle", lat, exp_lat);
    #1;
    wen_cpu = 1'b0;
    ren_cpu = 1'b0;
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            kind;
    req_exp_t      r;
    address_cpu = '0; wen_cpu = 1'b0; ren_cpu = 1'b0; wdata_cpu = '0; wmask_cpu = '0;
    address2 = '0; wen2 = 1'b0; ren2 = 1'b0; wdata2 = '0; wmask2 = '0;
    dn2.req_ready = '0; dn2.resp_valid = '0; dn2.resp_rdata = '0;
    m_rdata = '0;
    cfg_ready_delay = 0; cfg_resp_delay = 1; cfg_no_resp = 1'b0; cfg_noise = 1'b0; cfg_resp_data = '0;

    repeat (3) @(negedge clk);
    check("reset_req_valid", dn.req_valid, '0);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_rdata", rdata_cpu, '0);
    check("reset_stall", mem_stall, 1'b0);
    check("reset_fault", access_fault, 1'b0);
    check("reset_req_addr", dn.req_addr, '0);

    // Directed cases from the region map and timing rules.
    access(1'b0, 64'h8000_0010, '0, '0, 0, 1, 1'b0, 1'b0, 64'hDEAD_BEEF);
    access(1'b1, 64'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F, 5, 2, 1'b0, 1'b0, 64'h0BAD);
    access(1'b0, 64'h4000_0000, '0, '0, 0, 1, 1'b0, 1'b0, 64'h0);
    access(1'b0, 64'h0000_2000, '0, '0, 0, 1, 1'b1, 1'b0, 64'h0);
    access(1'b0, 64'h0000_3000, '0, '0, 1, 3, 1'b0, 1'b1, 64'hCAFE_F00D_1234_5678);
    access(1'b0, 64'h8000_0040, '0, '0, 0, 2, 1'b0, 1'b1, 64'hA5A5_5A5A_0000_FFFF);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       a = {32'h0, 1'b1, 31'($urandom)};
        1:       a = {36'h0, 28'($urandom)};
        default: a = {32'h0, 1'b0, 3'($urandom_range(1, 7)), 28'($urandom)};
      endcase
      access(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, MW'($urandom),
             $urandom_range(0, 3), $urandom_range(1, 4), ($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    // Reset while waiting for a response; the late response must be ignored.
    cfg_ready_delay = 0; cfg_resp_delay = 6; cfg_no_resp = 1'b0; cfg_noise = 1'b0;
    cfg_resp_data   = 64'h7777_8888_9999_AAAA;
    r.oh = 2'b01; r.addr = 64'h8000_0100; r.we = 1'b0; r.wdata = '0; r.wmask = '0;
    req_q.push_back(r);
    @(negedge clk);
    #1 address_cpu = 64'h8000_0100; wdata_cpu = '0; wmask_cpu = '0; ren_cpu = 1'b1;
    repeat (3) @(negedge clk);
    check("wait_stall_before_reset", mem_stall, 1'b1);
    #1 rstn = 1'b0; ren_cpu = 1'b0; m_rdata = '0;
    #1 check("reset_drops_req_valid", dn.req_valid, '0);
    @(negedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("late_resp_stall", mem_stall, 1'b0);
    check("late_resp_fault", access_fault, 1'b0);
    check("late_resp_req_valid", dn.req_valid, '0);
    check("late_resp_rdata", rdata_cpu, m_rdata);

    access(1'b0, 64'h0000_0040, '0, '0, 0, 1, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0);

    // Fully overlapping three-port map: port0 always wins.
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      @(negedge clk);
      #1 address2 = a; ren2 = 1'b1;
      @(negedge clk);
      check("overlap_req_valid", dn2.req_valid, 3'b001);
      check("overlap_req_addr", dn2.req_addr, a);
      #1 dn2.req_ready = 3'b001;
      @(negedge clk);
      #1 dn2.req_ready = '0; dn2.resp_valid = 3'b001;
      dn2.resp_rdata = {$urandom, $urandom, $urandom, $urandom, d};
      @(negedge clk);
      check("overlap_stall", stall2, 1'b0);
      check("overlap_fault", fault2, 1'b0);
      check("overlap_rdata", rdata2, d);
      #1 ren2 = 1'b0; dn2.resp_valid = '0;
    end

    repeat (4) @(negedge clk);
    check("core_queue_drained", core_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
